glitch_gen_top: RTL and testbench



---
 rtl/glitch_gen_top.sv | 129 ++++++++++++
 tb/tb_glitch_gen_top.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/glitch_gen_top.sv
// Clock-glitch generator: CLK/2 reference clock, CLK/DIV target clock, and one
// delayed extra high pulse per trigger. Optional feature macro: RETRIGGER_EN.
module glitch_gen_top #(
  parameter int DIV         = 12,
  parameter int LOCK_CYCLES = 1024,
  parameter int DELAY       = 16,
  parameter int GLITCH_W    = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic PMOD2,
  output logic PMOD1,
  output logic PMOD3,
  output logic D4,
  output logic D5
);

  localparam int LW = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam int DW = $clog2(DIV);
  localparam int PW = $clog2(DELAY + 1);

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] HALF      = DW'(DIV / 2);
  localparam logic [DW-1:0] G_START   = DW'(3 * DIV / 4);
  localparam logic [DW-1:0] G_END     = DW'(3 * DIV / 4 + GLITCH_W - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DELAY - 1);

  typedef enum logic [2:0] {
    S_LOCKING,
    S_ARMED,
    S_DELAYING,
    S_GLITCH,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            d5_q, d5_d;
  logic            d4_q, d4_d;
  logic            pmod1_q, pmod1_d;
  logic            pmod3_q, pmod3_d;
  logic            sync1_q, sync2_q, prev_q;
  logic            wrap, trig, glitch_on;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    d5_d       = d5_q;
    if (!d5_q) begin
      if (lock_cnt_q == LOCK_LAST) d5_d = 1'b1;
      else                         lock_cnt_d = lock_cnt_q + 1'b1;
    end

    dcnt_d = '0;
    if (d5_q) dcnt_d = (dcnt_q == DIV_LAST) ? '0 : dcnt_q + 1'b1;
    wrap = d5_q && (dcnt_q == DIV_LAST);
    trig = sync2_q && !prev_q;

    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      S_LOCKING: if (d5_q) state_d = S_ARMED;
      S_ARMED: begin
        if (trig) begin
          state_d = S_DELAYING;
          pcnt_d  = '0;
        end
      end
      S_DELAYING: begin
        if (wrap) begin
          if (pcnt_q == PCNT_LAST) state_d = S_GLITCH;
          else                     pcnt_d  = pcnt_q + 1'b1;
        end
      end
      S_GLITCH: if (dcnt_q == G_END) state_d = S_DONE;
      S_DONE: begin
`ifdef RETRIGGER_EN
        state_d = S_ARMED;
`else
        state_d = S_DONE;
`endif
      end
      default: state_d = S_LOCKING;
    endcase

    // Outputs are computed from next-state values so the registered PMOD3
    // lines up with the registered dcnt it is derived from.
    glitch_on = (state_q == S_GLITCH) && (dcnt_d >= G_START) && (dcnt_d <= G_END);
    pmod1_d   = d5_q ? !pmod1_q : 1'b0;
    pmod3_d   = d5_d && ((dcnt_d < HALF) || glitch_on);
    d4_d      = (state_d == S_ARMED);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_LOCKING;
      lock_cnt_q <= '0;
      dcnt_q     <= '0;
      pcnt_q     <= '0;
      d5_q       <= 1'b0;
      d4_q       <= 1'b0;
      pmod1_q    <= 1'b0;
      pmod3_q    <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      dcnt_q     <= dcnt_d;
      pcnt_q     <= pcnt_d;
      d5_q       <= d5_d;
      d4_q       <= d4_d;
      pmod1_q    <= pmod1_d;
      pmod3_q    <= pmod3_d;
      sync1_q    <= PMOD2;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
    end
  end

  assign PMOD1 = pmod1_q;
  assign PMOD3 = pmod3_q;
  assign D4    = d4_q;
  assign D5    = d5_q;

endmodule

// File: tb/tb_glitch_gen_top.sv
// Scoreboard bench for glitch_gen_top: expected output events are queued by the
// stimulus process and matched by an independent monitor.
module tb_glitch_gen_top;

  localparam int DIV = 12;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic PMOD2 = 1'b0;
  logic PMOD1, PMOD3, D4, D5;

  always #5 CLK = ~CLK;

  glitch_gen_top #(
    .DIV(12), .LOCK_CYCLES(1024), .DELAY(16), .GLITCH_W(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PMOD2(PMOD2),
    .PMOD1(PMOD1), .PMOD3(PMOD3), .D4(D4), .D5(D5)
  );

  localparam int EV_D5  = 0;
  localparam int EV_D4R = 1;
  localparam int EV_D4F = 2;
  localparam int EV_GL  = 3;

  typedef struct {
    int kind;
    int cyc;
    int width;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  // Clock edges counted from reset release: edge n leaves cyc == n.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int k, input int c, input int w);
    ev_t e;
    e.kind = k; e.cyc = c; e.width = w;
    exp_q.push_back(e);
  endtask

  task automatic report(input int k, input int c, input int w);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d cyc %0d width %0d required none", k, c, w);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != c || e.width != w) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d width %0d required kind %0d cyc %0d width %0d",
                 k, c, w, e.kind, e.cyc, e.width);
      end else begin
        $display("ok event kind %0d at cyc %0d width %0d", k, c, w);
      end
    end
  endtask

  // Monitor
  bit p1_prev, p3_prev, d4_prev, d5_prev;
  bit rise_valid, norm_valid;
  int rise_cyc, last_norm;

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        p1_prev = 0; p3_prev = 0; d4_prev = 0; d5_prev = 0;
        rise_valid = 0; norm_valid = 0;
      end else begin
        if (D5 && !d5_prev) report(EV_D5, cyc, 0);
        if (D4 && !d4_prev) report(EV_D4R, cyc, 0);
        if (!D4 && d4_prev) report(EV_D4F, cyc, 0);
        if (!D5) check("prelock_zero", int'({PMOD1, PMOD3, D4}), 0);
        if (d5_prev) check("pmod1_toggle", int'(PMOD1), int'(!p1_prev));
        if (PMOD3 && !p3_prev) begin
          rise_cyc   = cyc;
          rise_valid = 1;
        end
        if (!PMOD3 && p3_prev && rise_valid) begin
          if (cyc - rise_cyc == DIV / 2) begin
            if (norm_valid) check("pmod3_period", rise_cyc - last_norm, DIV);
            last_norm  = rise_cyc;
            norm_valid = 1;
          end else begin
            report(EV_GL, rise_cyc, cyc - rise_cyc);
          end
          rise_valid = 0;
        end
        p1_prev = PMOD1; p3_prev = PMOD3; d4_prev = D4; d5_prev = D5;
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic pulse(input int at);
    wait_cyc(at);
    PMOD2 = 1'b1;
    repeat (4) @(negedge CLK);
    PMOD2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // Trigger at edge 1100 is accepted at 1103 (dcnt 7); first wrap at 1108,
    // 16th wrap at 1288, glitch at dcnt 9 -> edge 1297.
    expect_ev(EV_D5, 1024, 0);
    expect_ev(EV_D4R, 1025, 0);
    expect_ev(EV_D4F, 1103, 0);
    expect_ev(EV_GL, 1297, 1);
`ifdef RETRIGGER_EN
    // DONE at 1298, ARMED at 1299; trigger at 1320 accepted at 1323 (dcnt 11),
    // first wrap 1324, 16th wrap 1504, glitch 1513, DONE 1514, ARMED 1515.
    expect_ev(EV_D4R, 1299, 0);
    expect_ev(EV_D4F, 1323, 0);
    expect_ev(EV_GL, 1513, 1);
    expect_ev(EV_D4R, 1515, 0);
`endif
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    pulse(5);
    pulse(1100);
    pulse(1150);
    pulse(1320);
    wait_cyc(1600);
`ifdef RETRIGGER_EN
    check("d4_final", int'(D4), 1);
`else
    check("d4_final", int'(D4), 0);
`endif
    check("pending_events_run1", exp_q.size(), 0);

    // Reset in the middle of the glitch, then a full relock.
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    expect_ev(EV_D5, 1024, 0);
    expect_ev(EV_D4R, 1025, 0);
    expect_ev(EV_D4F, 1103, 0);
    RST_N = 1'b1;
    pulse(1100);
    wait_cyc(1297);
    #2;
    check("glitch_before_reset", int'(PMOD3), 1);
    check("pending_events_run2", exp_q.size(), 0);
    RST_N = 1'b0;
    #1;
    check("async_reset_outputs", int'({PMOD1, PMOD3, D4, D5}), 0);
    repeat (3) @(negedge CLK);
    expect_ev(EV_D5, 1024, 0);
    expect_ev(EV_D4R, 1025, 0);
    RST_N = 1'b1;
    wait_cyc(1040);
    check("pending_events_run3", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
